// File: rtl/simon_sched.sv
// Sequencing controller for the SIMON key expander and a single-round datapath.
// Define SIMON_SCHED_KCACHE_EN to skip re-expansion when the same key and mode are resubmitted.
module simon_sched #(
  parameter int unsigned ROUNDS_64  = 44,
  parameter int unsigned ROUNDS_128 = 68,
  parameter int unsigned IDX_WIDTH  = 7
) (
  input  logic                 ck,
  input  logic                 nrst,
  input  logic                 mode,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 kx_nrst,
  output logic                 kx_valid,
  input  logic                 kx_ready,
  input  logic                 kx_done,
  output logic                 kx_mode,
`ifdef SIMON_SCHED_KCACHE_EN
  input  logic [127:0]         key_in,
`endif
  output logic                 rnd_load,
  output logic                 rnd_step,
  output logic [IDX_WIDTH-1:0] rnd_idx,
  output logic [31:0]          blk_count
);

  typedef enum logic [2:0] {
    StIdle, StKrst, StKload, StKwait, StReady, StRun, StOut
  } state_e;

  state_e                state_q, state_d;
  logic                  kx_mode_q, kx_mode_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [31:0]           count_q, count_d;
  logic [IDX_WIDTH-1:0]  last_idx;
  logic                  cache_hit;

`ifdef SIMON_SCHED_KCACHE_EN
  logic [127:0] cache_key_q, cache_key_d;
  logic         cache_mode_q, cache_mode_d;
  logic         cache_vld_q, cache_vld_d;

  assign cache_hit = cache_vld_q && (cache_key_q == key_in) && (cache_mode_q == mode);
`else
  assign cache_hit = 1'b0;
`endif

  assign last_idx = kx_mode_q ? IDX_WIDTH'(ROUNDS_128 - 1) : IDX_WIDTH'(ROUNDS_64 - 1);

  always_comb begin
    state_d   = state_q;
    kx_mode_d = kx_mode_q;
    idx_d     = idx_q;
    count_d   = count_q;
`ifdef SIMON_SCHED_KCACHE_EN
    cache_key_d  = cache_key_q;
    cache_mode_d = cache_mode_q;
    cache_vld_d  = cache_vld_q;
`endif
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          kx_mode_d = mode;
          state_d   = StKrst;
        end
      end
      StKrst: state_d = StKload;
      StKload: begin
        if (kx_ready) begin
          state_d = StKwait;
`ifdef SIMON_SCHED_KCACHE_EN
          // Host still holds the key bus stable until this handshake.
          cache_key_d  = key_in;
          cache_mode_d = kx_mode_q;
          cache_vld_d  = 1'b1;
`endif
        end
      end
      StKwait: begin
        if (kx_done) state_d = StReady;
      end
      StReady: begin
        if (key_valid) begin
          if (!cache_hit) begin
            kx_mode_d = mode;
            state_d   = StKrst;
          end
        end else if (blk_valid) begin
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (idx_q == last_idx) state_d = StOut;
        else                   idx_d   = idx_q + 1'b1;
      end
      StOut: begin
        if (out_ready) begin
          count_d = count_q + 32'd1;
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!nrst) begin
      state_q   <= StIdle;
      kx_mode_q <= 1'b0;
      idx_q     <= '0;
      count_q   <= '0;
`ifdef SIMON_SCHED_KCACHE_EN
      cache_key_q  <= '0;
      cache_mode_q <= 1'b0;
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      kx_mode_q <= kx_mode_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
`ifdef SIMON_SCHED_KCACHE_EN
      cache_key_q  <= cache_key_d;
      cache_mode_q <= cache_mode_d;
      cache_vld_q  <= cache_vld_d;
`endif
    end
  end

  assign key_ready = (state_q == StIdle) || (state_q == StReady);
  assign blk_ready = (state_q == StReady) && !key_valid;
  assign out_valid = (state_q == StOut);
  assign kx_nrst   = nrst && (state_q != StKrst);
  assign kx_valid  = (state_q == StKload);
  assign kx_mode   = kx_mode_q;
  assign rnd_load  = blk_ready && blk_valid;
  assign rnd_step  = (state_q == StRun);
  assign rnd_idx   = idx_q;
  assign blk_count = count_q;

endmodule

// File: tb/tb_simon_sched.sv
// Self-checking bench for simon_sched with a behavioural key-expander model and
// a block scoreboard of expected round counts and completion counts.
module tb_simon_sched;

  localparam int unsigned IdxW = 7;

  logic            ck = 1'b0;
  logic            nrst, mode, key_valid, blk_valid, out_ready;
  logic            key_ready, blk_ready, out_valid;
  logic            kx_nrst, kx_valid, kx_ready, kx_done, kx_mode;
  logic            rnd_load, rnd_step;
  logic [IdxW-1:0] rnd_idx;
  logic [31:0]     blk_count;
`ifdef SIMON_SCHED_KCACHE_EN
  logic [127:0]    key_in_v;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;

  typedef struct { int n; int cnt; } blk_exp_t;
  blk_exp_t sb_q[$];

  always #5 ck = ~ck;

  simon_sched #(.ROUNDS_64(44), .ROUNDS_128(68), .IDX_WIDTH(IdxW)) u_dut (
    .ck        (ck),
    .nrst      (nrst),
    .mode      (mode),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .kx_nrst   (kx_nrst),
    .kx_valid  (kx_valid),
    .kx_ready  (kx_ready),
    .kx_done   (kx_done),
    .kx_mode   (kx_mode),
`ifdef SIMON_SCHED_KCACHE_EN
    .key_in    (key_in_v),
`endif
    .rnd_load  (rnd_load),
    .rnd_step  (rnd_step),
    .rnd_idx   (rnd_idx),
    .blk_count (blk_count)
  );

  // Expander model: k_ready rises after 3 cycles of k_valid, exp_valid 81 cycles after accept.
  int   kdly, kcnt;
  logic kacc;
  always @(posedge ck) begin
    if (!kx_nrst) begin
      kdly <= 0; kcnt <= 0; kacc <= 1'b0; kx_ready <= 1'b0; kx_done <= 1'b0;
    end else if (!kacc) begin
      if (kx_valid && kx_ready) begin
        kacc <= 1'b1; kx_ready <= 1'b0; kcnt <= 81;
      end else if (kx_valid) begin
        kdly <= kdly + 1;
        kx_ready <= (kdly >= 2);
      end
    end else if (kcnt > 1) begin
      kcnt <= kcnt - 1;
    end else begin
      kx_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step_cycle();
    @(posedge ck);
    #1;
  endtask

  // Submit a key and follow the full expansion sequence back to READY.
  task automatic do_key(input logic m, input bit with_blk);
    int n_rst, n_kv, cyc;
    mode = m; key_valid = 1'b1; blk_valid = with_blk;
    #1;
    if (with_blk) begin
      check("key_prio_blk_ready", blk_ready, 0);
      check("key_prio_rnd_load", rnd_load, 0);
    end
    step_cycle();
    key_valid = 1'b0; blk_valid = 1'b0;
    check("krst_key_ready", key_ready, 0);
    n_rst = 0; n_kv = 0; cyc = 0;
    while (!key_ready && cyc < 400) begin
      if (!kx_nrst) n_rst++;
      if (kx_valid) n_kv++;
      step_cycle();
      cyc++;
    end
    check("key_timeout", cyc < 400, 1);
    check("kx_nrst_pulses", n_rst, 1);
    check("kx_valid_cycles", n_kv, 4);
    check("ready_after_done", kx_done, 1);
    check("kx_mode", kx_mode, m);
  endtask

  task automatic run_block(input int n, input int hold);
    blk_exp_t e, got;
    int lat, steps, idx_err, both, hold_err;
    e.n = n; e.cnt = model_cnt + 1;
    blk_valid = 1'b1;
    #1;
    check("blk_ready", blk_ready, 1);
    check("rnd_load", rnd_load, 1);
    sb_q.push_back(e);
    model_cnt++;
    step_cycle();
    blk_valid = 1'b0;
    lat = 1; steps = 0; idx_err = 0; both = 0;
    while (!out_valid && lat < 300) begin
      if (rnd_step) begin
        if (rnd_idx != IdxW'(steps)) idx_err++;
        steps++;
      end
      if (rnd_load) both++;
      step_cycle();
      lat++;
    end
    got = sb_q.pop_front();
    check("latency", lat, got.n + 1);
    check("step_count", steps, got.n);
    check("idx_sequence_errs", idx_err, 0);
    check("load_during_run", both, 0);
    check("idx_hold", rnd_idx, got.n - 1);
    hold_err = 0;
    for (int i = 0; i < hold; i++) begin
      if (!out_valid || rnd_step) hold_err++;
      step_cycle();
    end
    if (hold > 0) check("out_valid_held", hold_err, 0);
    check("count_before_hs", blk_count, got.cnt - 1);
    out_ready = 1'b1;
    step_cycle();
    out_ready = 1'b0;
    check("out_valid_dropped", out_valid, 0);
    check("blk_ready_after", blk_ready, 1);
    check("blk_count", blk_count, got.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov;
    nrst = 1'b0; mode = 1'b0; key_valid = 1'b0; blk_valid = 1'b0; out_ready = 1'b0;
`ifdef SIMON_SCHED_KCACHE_EN
    key_in_v = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
`endif
    step_cycle();
    step_cycle();
    check("rst_key_ready", key_ready, 1);
    check("rst_blk_ready", blk_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rnd_step", rnd_step, 0);
    check("rst_blk_count", blk_count, 0);
    check("rst_kx_nrst", kx_nrst, 0);
    check("rst_rnd_idx", rnd_idx, 0);
    nrst = 1'b1;
    step_cycle();
    check("idle_kx_nrst", kx_nrst, 1);
    check("idle_blk_ready", blk_ready, 0);

    do_key(1'b0, 1'b0);
    check("ready_blk_ready", blk_ready, 1);
    run_block(44, 5);
    run_block(44, 0);

    // Re-key to 128/128 while a block is also offered.
    do_key(1'b1, 1'b1);
    run_block(68, 2);

    // Reset in the middle of a 128/128 run.
    blk_valid = 1'b1;
    step_cycle();
    blk_valid = 1'b0;
    while (!(rnd_step && rnd_idx == IdxW'(20)) && !out_valid) step_cycle();
    check("mid_idx", rnd_idx, 20);
    nrst = 1'b0;
    step_cycle();
    nrst = 1'b1;
    check("mid_rst_step", rnd_step, 0);
    check("mid_rst_idle", key_ready, 1);
    check("mid_rst_count", blk_count, 0);
    check("mid_rst_kx_mode", kx_mode, 0);
    model_cnt = 0;
    ov = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid || rnd_step) ov++;
      step_cycle();
    end
    check("mid_rst_no_out", ov, 0);

    do_key(1'b0, 1'b0);
`ifdef SIMON_SCHED_KCACHE_EN
    // Same key and mode: stays READY without touching the expander.
    mode = 1'b0; key_valid = 1'b1;
    #1;
    check("hit_key_ready", key_ready, 1);
    step_cycle();
    key_valid = 1'b0;
    #1;
    check("hit_kx_nrst", kx_nrst, 1);
    check("hit_kx_valid", kx_valid, 0);
    check("hit_blk_ready", blk_ready, 1);
    step_cycle();
    check("hit_kx_valid2", kx_valid, 0);
    run_block(44, 1);
    key_in_v = 128'h11111111_22222222_33333333_44444444;
    do_key(1'b0, 1'b0);
`else
    do_key(1'b0, 1'b0);
`endif
    run_block(44, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simon_sched.md
Name: simon_sched

Overview:
- Controller that sequences the SIMON key expander and an external single-round datapath for block encryption.
- Accepts a key from the host, pulses the expander's local reset, loads the key and waits for expansion to finish.
- Then accepts blocks one at a time and steps the round unit through every round, driving the round-key index.
- Sits between the host interface and the simon_kexp / round-unit pair; carries no key or block data itself.

Parameters:
- ROUNDS_64, 44, round count for 64/128 mode.
- ROUNDS_128, 68, round count for 128/128 mode.
- IDX_WIDTH, 7, width of the round-key index; must satisfy 2^IDX_WIDTH > max(ROUNDS_64, ROUNDS_128).

Ports:
- ck  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- mode  in  1  cipher mode sampled with key; 0 = 64/128, 1 = 128/128 (SIMON_MODE_* encoding).
- key_valid  in  1  host key request.
- key_ready  out  1  controller can take a new key.
- blk_valid  in  1  host block available (data routed directly to round unit).
- blk_ready  out  1  block accepted this cycle when high with blk_valid.
- out_valid  out  1  round-unit result is final.
- out_ready  in  1  host consumes the result.
- kx_nrst  out  1  local reset to expander; equals nrst AND NOT internal reset pulse.
- kx_valid  out  1  to expander k_valid.
- kx_ready  in  1  from expander k_ready.
- kx_done  in  1  from expander exp_valid.
- kx_mode  out  1  latched mode to expander and round unit.
- rnd_load  out  1  round unit loads block input this cycle.
- rnd_step  out  1  round unit applies one round this cycle.
- rnd_idx  out  IDX_WIDTH  round-key index used with rnd_step.
- blk_count  out  32  number of blocks completed since reset, wraps.

Behaviour:
- Reset values:
  - State is IDLE.
  - key_ready = 1; every other output is 0, except kx_nrst, which follows nrst.
  - kx_mode = 0, rnd_idx = 0, blk_count = 0.
- States:
  - IDLE:
    - key_ready = 1.
    - On key_valid: latch mode into kx_mode, go to KRST.
  - KRST:
    - One cycle with kx_nrst = 0.
    - Then go to KLOAD.
  - KLOAD:
    - kx_valid = 1 until the cycle kx_ready = 1 and kx_valid = 1 coincide.
    - Then go to KWAIT.
  - KWAIT:
    - Wait for kx_done = 1, then go to READY.
    - No timeout.
  - READY:
    - key_ready = 1.
    - blk_ready = NOT key_valid.
    - key_valid has priority: latch mode, go to KRST.
    - Otherwise blk_valid AND blk_ready:
      - rnd_load = 1 that cycle.
      - rnd_idx cleared.
      - Go to RUN.
  - RUN:
    - rnd_step = 1 every cycle.
    - rnd_idx = 0..N-1 in consecutive cycles, with N = ROUNDS_128 if kx_mode else ROUNDS_64.
    - After the step with rnd_idx = N-1, go to OUT.
  - OUT:
    - out_valid = 1, held until out_ready.
    - On handshake: blk_count += 1, go to READY.
    - Same-cycle out_ready with out_valid completes the handshake.
- Latency: block accept to first out_valid = N+1 cycles (45 for 64/128, 69 for 128/128).
- Handshakes:
  - key_valid and blk_valid are ignored in KRST, KLOAD, KWAIT, RUN and OUT.
  - key_ready = 0 and blk_ready = 0 in those states.
- Key source: the host holds the key bus stable from key_valid until the expander accepts it in KLOAD. The controller does not register the key.
- Exclusivity: rnd_load and rnd_step are never high together.
- rnd_idx: holds its last value outside RUN.
- Reset mid-operation: nrst low in any state returns to IDLE next edge. All outputs take reset values; any block in flight is discarded.
- blk_count wraps from 0xFFFFFFFF to 0.

Optional Feature:
- Macro: SIMON_SCHED_KCACHE_EN.
- Defined:
  - The controller stores a 128-bit copy of the last expanded key plus its mode and a cached-valid bit.
  - The cached-valid bit is cleared on reset.
  - In READY, a key_valid whose key and mode equal the cache skips KRST/KLOAD/KWAIT; state stays READY and no kx_nrst pulse occurs.
  - key_ready behaviour is unchanged.
  - Adds input key_in[127:0]. The cache is written when leaving KLOAD.
- Undefined:
  - No cache and no key_in port.
  - Every key request re-expands.

Test Plan:
- Reset: nrst = 0 for 2 cycles -> key_ready = 1, blk_ready = 0, out_valid = 0, rnd_step = 0, blk_count = 0, kx_nrst = 0 during reset.
- 64/128 key (mode = 0), expander model with 3-cycle kx_ready delay and kx_done 81 cycles later:
  - exactly one kx_nrst low cycle;
  - kx_valid held until the kx_ready handshake;
  - READY is reached after kx_done.
- Block in 64/128:
  - rnd_load for 1 cycle;
  - rnd_step for 44 cycles with rnd_idx 0..43;
  - out_valid on cycle 45;
  - out_ready held low 5 cycles -> out_valid stays high;
  - blk_count = 1 after handshake.
- 128/128 re-key while READY with blk_valid and key_valid both high -> key wins, blk_ready = 0, KRST entered; the next block uses 68 steps, rnd_idx ending at 67.
- nrst low during RUN at rnd_idx = 20 -> state IDLE next edge, rnd_step = 0, out_valid never asserts.
- SIMON_SCHED_KCACHE_EN defined: same key and mode resubmitted -> no kx_nrst pulse, no kx_valid, blk_ready = 1 the next cycle; a different key -> full re-expansion.
